ram_arbiter: RTL
================

# ram_arbiter

Sequences all traffic to the single byte-wide, synchronous-read RAM. It arbitrates between two requesters: instruction fetch (IF, 4-byte reads) and the MEM stage (1/2/4-byte loads and stores). Each granted request runs to completion as a byte-by-byte transaction, and a one-cycle done pulse returns assembled data. It sits between the fetch/cache path and MEM on one side and the RAM port on the other. It exports the current owner so the pipeline staller can freeze the stages that must wait.

## Interface
No parameters.
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; low = pause
- if_req  in  1  IF read request, held until if_done
- if_addr  in  32  IF byte address of word
- if_done  out  1  one-cycle pulse, if_rdata valid
- if_rdata  out  32  fetched word, little-endian
- mem_req  in  1  MEM request, held until mem_done
- mem_we  in  1  1 = store, 0 = load
- mem_len  in  2  00 byte, 01 half, 10/11 word
- mem_addr  in  32  MEM byte address
- mem_wdata  in  32  store data, low bytes used
- mem_done  out  1  one-cycle pulse; for loads mem_rdata valid
- mem_rdata  out  32  load data, zero-extended (MEM sign-extends)
- ram_wr  out  1  1 = write byte this cycle
- ram_addr  out  32  RAM byte address
- ram_wdata  out  8  RAM write byte
- ram_rdata  in  8  RAM read byte; corresponds to ram_addr of previous cycle
- owner  out  2  0 none, 1 IF, 2 MEM

## Operation
- States: IDLE, ISSUE, DRAIN, DONE. Registers latched at grant:
  - sel (IF/MEM)
  - we
  - n (1, 2 or 4)
  - base
  - wdata
  - cnt (0..3)
  - acc (32-bit)
- IDLE: if mem_req, grant MEM. Otherwise, if if_req, grant IF. Fixed priority, MEM over IF. On grant: cnt=0, acc=0, go to ISSUE.
- Grants are non-preemptive. A request arriving during a transaction waits, even MEM arriving during an IF transaction.
- ISSUE: drive ram_addr = base+cnt, with 32-bit modulo wrap.
  - Writes: ram_wr=1, ram_wdata = wdata[8cnt+7:8cnt].
  - Reads: ram_wr=0, ram_wdata=0.
  - Reads with cnt>0 capture ram_rdata into acc byte cnt-1.
  - When cnt==n-1: writes go to DONE; reads go to DRAIN. Otherwise cnt++.
- DRAIN: capture ram_rdata into acc byte n-1, go to DONE. ram_wr=0.
- DONE: assert done of sel for one cycle. rdata = acc; unused upper bytes are 0. Go to IDLE. Requests sampled in DONE are ignored.
- Requester rule: drop req, or present the next request, in the cycle after done.
- owner = sel in ISSUE/DRAIN/DONE, 0 in IDLE.
- Pause (rdy=0):
  - All state, cnt and acc are frozen.
  - ram_wr=0; done outputs are 0.
  - ram_addr = address of the most recently issued byte (register last_addr), so the first rdy=1 cycle after the pause presents the correct pending byte.
- Reset, including mid-transaction: state IDLE; cnt, acc, last_addr, ram_addr = 0; ram_wr = 0; both done = 0; owner = 0. No done pulse is produced for an aborted transaction.

## Timing
- Grant is sampled in IDLE cycle T. Bytes are issued in T+1..T+n.
- Read: DRAIN at T+n+1, done at T+n+2. Word read: done at T+6.
- Write: last byte at T+n, done at T+n+1. Byte store: done at T+2. Word store: done at T+5.
- Back-to-back: the earliest next grant is in the IDLE cycle after DONE, giving a 2-cycle gap between transactions.
- Each pause cycle adds exactly one cycle of latency.
- rdata outputs hold their value until the next DONE. done is registered, with no combinational path from req.

## Structure
- Shared constants go in the common macro header:
  - owner codes (OWN_NONE/IF/MEM)
  - len codes (LEN_B/H/W)
  - state encodings
- The staller consumes owner from this header.
- No sub-module. Counter, byte lane select and assembly are a few lines each; keep the block flat.

## Test plan
- IF word read at 0x100, RAM bytes 0x13,0x05,0x10,0x00 -> owner=1 during T+1..T+6; if_rdata=0x00100513 with if_done at T+6.
- MEM half store at 0xFFFFFFFF, wdata=0xBEEF -> ram writes 0xEF @0xFFFFFFFF then 0xBE @0x00000000 (wrap); mem_done at T+3.
- mem_req and if_req rise together -> MEM granted first. IF is granted in the IDLE cycle after mem_done, and owner goes 2→0→1.
- mem_req rises at T+2 during an IF read -> IF completes undisturbed at T+6. MEM is granted at T+7.
- Word read with rdy=0 for 3 cycles at T+3 -> ram_wr stays 0 and ram_addr holds base+1; correct data returns with done at T+9.
- rst asserted at T+2 of a word store -> next cycle state is IDLE, owner=0, ram_wr=0, and no mem_done. A reissued store completes normally.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// rtl/ram_arbiter_pkg.sv - shared owner, length and state codes for the RAM arbiter
package ram_arbiter_pkg;

    // Current owner of the RAM port, consumed by the pipeline staller
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_IF   = 2'd1;
    localparam logic [1:0] OWN_MEM  = 2'd2;

    // MEM access length codes; 2'b11 is treated as a word
    localparam logic [1:0] LEN_B = 2'b00;
    localparam logic [1:0] LEN_H = 2'b01;
    localparam logic [1:0] LEN_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Index of the last byte of an access (n-1), so the counter compares directly
    function automatic logic [1:0] len_last(input logic [1:0] len);
        logic [1:0] r;
        if (len == LEN_B) begin
            r = 2'd0;
        end else if (len == LEN_H) begin
            r = 2'd1;
        end else begin
            r = 2'd3;
        end
        return r;
    endfunction

endpackage

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - byte-serial arbiter of IF and MEM traffic onto the single byte-wide RAM
module ram_arbiter
    import ram_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_rdata,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [1:0]  mem_len,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_done,
    output logic [31:0] mem_rdata,
    output logic        ram_wr,
    output logic [31:0] ram_addr,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata,
    output logic [1:0]  owner
);

    state_t      state_q;
    logic        sel_mem_q;
    logic        we_q;
    logic [1:0]  last_q;
    logic [1:0]  cnt_q;
    logic [31:0] base_q;
    logic [31:0] wdata_q;
    logic [31:0] acc_q;
    logic [31:0] last_addr_q;
    logic [31:0] if_rdata_q;
    logic [31:0] mem_rdata_q;

    logic [31:0] issue_addr;
    logic        issuing;
    logic        capture;
    logic [1:0]  cap_lane;
    logic [31:0] wdata_shift;
    logic [31:0] acc_d;

    // Address wraps modulo 2^32 naturally through the 32-bit add
    assign issue_addr  = base_q + {30'd0, cnt_q};
    assign issuing     = rdy && (state_q == ST_ISSUE);
    assign wdata_shift = wdata_q >> {cnt_q, 3'b000};

    // RAM data lags its address by one cycle, so byte k lands while byte k+1 is issued
    assign capture  = rdy && !we_q &&
                      (((state_q == ST_ISSUE) && (cnt_q != 2'd0)) || (state_q == ST_DRAIN));
    assign cap_lane = (state_q == ST_DRAIN) ? last_q : (cnt_q - 2'd1);

    // Merge the arriving read byte into its lane of the accumulator
    always_comb begin
        acc_d = acc_q;
        if (capture) begin
            acc_d[{cap_lane, 3'b000} +: 8] = ram_rdata;
        end
    end

    // Transaction sequencer: grant, byte issue, final capture and done
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sel_mem_q   <= 1'b0;
            we_q        <= 1'b0;
            last_q      <= 2'd0;
            cnt_q       <= 2'd0;
            base_q      <= 32'd0;
            wdata_q     <= 32'd0;
            acc_q       <= 32'd0;
            last_addr_q <= 32'd0;
            if_rdata_q  <= 32'd0;
            mem_rdata_q <= 32'd0;
        end else if (rdy) begin
            acc_q <= acc_d;
            case (state_q)
                ST_IDLE: begin
                    if (mem_req) begin
                        sel_mem_q <= 1'b1;
                        we_q      <= mem_we;
                        last_q    <= len_last(mem_len);
                        base_q    <= mem_addr;
                        wdata_q   <= mem_wdata;
                        cnt_q     <= 2'd0;
                        acc_q     <= 32'd0;
                        state_q   <= ST_ISSUE;
                    end else if (if_req) begin
                        sel_mem_q <= 1'b0;
                        we_q      <= 1'b0;
                        last_q    <= 2'd3;
                        base_q    <= if_addr;
                        wdata_q   <= 32'd0;
                        cnt_q     <= 2'd0;
                        acc_q     <= 32'd0;
                        state_q   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    last_addr_q <= issue_addr;
                    if (cnt_q == last_q) begin
                        state_q <= we_q ? ST_DONE : ST_DRAIN;
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                ST_DRAIN: begin
                    state_q <= ST_DONE;
                    if (sel_mem_q) begin
                        mem_rdata_q <= acc_d;
                    end else begin
                        if_rdata_q <= acc_d;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // During a pause the port re-presents the last issued byte so its data is valid on resume
    assign ram_wr    = issuing && we_q;
    assign ram_addr  = issuing ? issue_addr : last_addr_q;
    assign ram_wdata = (issuing && we_q) ? wdata_shift[7:0] : 8'd0;

    assign if_done   = rdy && (state_q == ST_DONE) && !sel_mem_q;
    assign mem_done  = rdy && (state_q == ST_DONE) && sel_mem_q;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;

    assign owner = (state_q == ST_IDLE) ? OWN_NONE : (sel_mem_q ? OWN_MEM : OWN_IF);

endmodule
